gpio_image_loader: RTL and testbench
====================================

GPIO_IMAGE_LOADER -- requirements
Module: gpio_image_loader

Interface
REQ-001 Parameter BASE_ADDR, default 18'h00000, first data-memory address written.
REQ-002 Parameter IMG_BYTES, default 18'd62500, bytes per load; legal range 1..2^18-1.
REQ-003 clk  input  1  system clock; memory samples on falling edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  synchronous load enable; low aborts or idles.
REQ-006 host_valid  input  1  asynchronous host strobe, four-phase handshake.
REQ-007 host_data  input  8  host byte; stable while host_valid high.
REQ-008 host_ack  output  1  registered acknowledge to host.
REQ-009 mem_address  output  18  data-memory address.
REQ-010 mem_data  output  8  data-memory write byte.
REQ-011 mem_wren  output  1  data-memory write enable, one-cycle pulse per byte.
REQ-012 busy  output  1  high in any state except IDLE and DONE.
REQ-013 done  output  1  high while in DONE.
REQ-014 checksum  output  8  running checksum; present only with LOADER_CHECKSUM_EN.

Function
REQ-015 host_valid SHALL pass a two-flop synchronizer; the FSM SHALL use only the synchronized value valid_s.
REQ-016 States: IDLE, WAIT_VALID, WRITE, WAIT_RELEASE, DONE.
REQ-017 IDLE: count=0, outputs low; enable=1 -> WAIT_VALID next cycle.
REQ-018 WAIT_VALID: valid_s=1 -> capture host_data into mem_data, go to WRITE.
REQ-019 WRITE: mem_wren=1 for exactly one cycle, mem_address=(BASE_ADDR+count) mod 2^18; next state WAIT_RELEASE.
REQ-020 WAIT_RELEASE: host_ack=1; valid_s=0 -> host_ack=0, count+1; if new count==IMG_BYTES -> DONE, else WAIT_VALID.
REQ-021 Latency from valid_s rise to mem_wren: 1 cycle; from valid_s rise to host_ack: 2 cycles.
REQ-022 At most one write per handshake; valid_s staying high SHALL NOT cause further writes.
REQ-023 mem_data and mem_address SHALL remain stable from the WRITE cycle until the next capture.
REQ-024 DONE: done=1, busy=0, no writes, host_valid ignored; enable=0 -> IDLE.
REQ-025 enable=0 in any busy state -> IDLE next cycle: host_ack=0, mem_wren=0, count=0, partial data kept in memory.
REQ-026 enable=0 in the same cycle as a WRITE: the write completes, then IDLE.
REQ-027 IMG_BYTES=1: one handshake -> DONE.
REQ-028 BASE_ADDR+count overflowing 18 bits SHALL wrap to 0.
REQ-029 All outputs SHALL be registered; no combinational path from host inputs to outputs.

Reset
REQ-030 rst=1 SHALL force IDLE, count=0, synchronizer flops=0, host_ack=0, mem_wren=0, mem_address=BASE_ADDR, mem_data=0, busy=0, done=0, checksum=0.
REQ-031 rst mid-transfer SHALL abort immediately with no further write; the host sees host_ack drop asynchronously.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: checksum port exists, set to 0 on IDLE->WAIT_VALID, updated in WRITE to checksum+mem_data mod 256, held in DONE.
REQ-033 Macro LOADER_CHECKSUM_EN undefined: no checksum port and no checksum logic; all other behaviour identical.

Verification
REQ-034 IMG_BYTES=4, BASE_ADDR=0x00100, host sends 0x11,0x22,0x33,0x44 -> single mem_wren pulses at 0x00100..0x00103 with those bytes, done=1 after 4th ack release.
REQ-035 host_valid held high 20 cycles -> exactly one mem_wren, host_ack high until 2 cycles after host_valid falls.
REQ-036 enable dropped after 2 of 4 bytes -> IDLE, count=0; re-enable with 4 bytes -> writes restart at BASE_ADDR.
REQ-037 BASE_ADDR=0x3FFFE, IMG_BYTES=3 -> writes to 0x3FFFE, 0x3FFFF, 0x00000.
REQ-038 rst asserted while in WAIT_RELEASE -> host_ack=0, busy=0 immediately; no write occurs during reset.
REQ-039 LOADER_CHECKSUM_EN, bytes 0xFF,0x02,0x10 -> checksum=0x11 in DONE.

Source files
------------

// File: rtl/gpio_image_loader.sv
// Host-to-memory byte loader: four-phase host handshake, one data-memory write per byte.
// Optional running checksum output enabled by defining LOADER_CHECKSUM_EN.
module gpio_image_loader #(
  parameter logic [17:0] BASE_ADDR = 18'h00000,
  parameter int unsigned IMG_BYTES = 62500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  output logic        host_ack,
  output logic [17:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  output logic        busy,
  output logic        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VALID,
    WRITE,
    WAIT_RELEASE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              sync_q1;
  logic              valid_s;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_n;
  logic [ADDR_W-1:0] count_inc;

  assign count_inc = count + ADDR_W'(1);

  // Two-flop synchronizer for the asynchronous host strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      valid_s <= 1'b0;
    end else begin
      sync_q1 <= host_valid;
      valid_s <= sync_q1;
    end
  end

  // State and byte-count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // Next state; dropping enable returns to IDLE from any busy state
  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: begin
        count_n = '0;
        if (enable) state_n = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (!enable) begin
          state_n = IDLE;
          count_n = '0;
        end else if (valid_s) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (!enable) begin
          state_n = IDLE;
          count_n = '0;
        end else begin
          state_n = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!enable) begin
          state_n = IDLE;
          count_n = '0;
        end else if (!valid_s) begin
          count_n = count_inc;
          state_n = (count_inc == IMG_LAST) ? DONE : WAIT_VALID;
        end
      end
      DONE: begin
        if (!enable) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_ack    <= 1'b0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_address <= BASE_ADDR;
      mem_data    <= '0;
    end else begin
      host_ack <= (state_n == WAIT_RELEASE);
      mem_wren <= (state_n == WRITE);
      busy     <= (state_n == WAIT_VALID) || (state_n == WRITE) || (state_n == WAIT_RELEASE);
      done     <= (state_n == DONE);
      if ((state == WAIT_VALID) && (state_n == WRITE)) begin
        mem_data    <= DATA_W'(host_data);
        mem_address <= BASE_ADDR + count;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running mod-256 sum of every byte written since the load started
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && (state_n == WAIT_VALID)) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + mem_data;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_image_loader.sv
// Directed bench for gpio_image_loader: three instances (normal, address wrap, single byte).
`timescale 1ns/1ps
module tb_gpio_image_loader;

  localparam int N = 3;

  typedef struct packed {
    logic [1:0]  g;
    logic [17:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [N];
  logic        hv   [N];
  logic [7:0]  hd   [N];
  logic        ack  [N];
  logic [17:0] addr [N];
  logic [7:0]  md   [N];
  logic        wren [N];
  logic        busy [N];
  logic        done [N];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum [N];
  logic [7:0]  msum [N];
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  expq [$];
  int   mcnt [N];
  int   wr_seen [N];
  logic prev_wren [N];
  logic [17:0] last_a [N];
  logic [7:0]  last_d [N];

  always #5 clk = ~clk;

  function automatic logic [17:0] base_of(input int g);
    case (g)
      0:       return 18'h00100;
      1:       return 18'h3FFFE;
      default: return 18'h00055;
    endcase
  endfunction

  function automatic int img_of(input int g);
    case (g)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam logic [17:0] B = (g == 0) ? 18'h00100 : (g == 1) ? 18'h3FFFE : 18'h00055;
    localparam int unsigned I = (g == 0) ? 4 : (g == 1) ? 3 : 1;
    gpio_image_loader #(.BASE_ADDR(B), .IMG_BYTES(I)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (en[g]),
      .host_valid  (hv[g]),
      .host_data   (hd[g]),
      .host_ack    (ack[g]),
      .mem_address (addr[g]),
      .mem_data    (md[g]),
      .mem_wren    (wren[g]),
      .busy        (busy[g]),
      .done        (done[g])
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum    (csum[g])
`endif
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle check of writes against the expected-write queue and output invariants
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        prev_wren[g] <= 1'b0;
        last_a[g]    <= base_of(g);
        last_d[g]    <= 8'h00;
      end else begin
        check("wren_ack_exclusive", 32'(wren[g] & ack[g]), 32'd0);
        check("busy_done_exclusive", 32'(busy[g] & done[g]), 32'd0);
        if (wren[g]) begin
          check("wren_single_cycle", 32'(prev_wren[g]), 32'd0);
          wr_seen[g] <= wr_seen[g] + 1;
          if (expq.size() == 0) begin
            check("write_expected", 32'(expq.size()), 32'd1);
          end else begin
            check("write_instance", 32'(g), 32'(expq[0].g));
            check("write_addr", 32'(addr[g]), 32'(expq[0].a));
            check("write_data", 32'(md[g]), 32'(expq[0].d));
            void'(expq.pop_front());
          end
          last_a[g] <= addr[g];
          last_d[g] <= md[g];
        end else begin
          check("addr_stable", 32'(addr[g]), 32'(last_a[g]));
          check("data_stable", 32'(md[g]), 32'(last_d[g]));
        end
        prev_wren[g] <= wren[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [7:0] b);
    wr_t e;
    e.g = 2'(g);
    e.a = 18'((32'(base_of(g)) + 32'(mcnt[g])) % 32'h40000);
    e.d = b;
    expq.push_back(e);
    mcnt[g]++;
`ifdef LOADER_CHECKSUM_EN
    msum[g] = msum[g] + b;
`endif
  endtask

  task automatic start(input int g);
    en[g] = 1'b1;
    mcnt[g] = 0;
`ifdef LOADER_CHECKSUM_EN
    msum[g] = 8'h00;
`endif
    tick();
    check("busy_on_enable", 32'(busy[g]), 32'd1);
    check("done_on_enable", 32'(done[g]), 32'd0);
  endtask

  task automatic stop(input int g);
    en[g] = 1'b0;
    tick();
    check("busy_after_disable", 32'(busy[g]), 32'd0);
    check("ack_after_disable", 32'(ack[g]), 32'd0);
    check("done_after_disable", 32'(done[g]), 32'd0);
    mcnt[g] = 0;
  endtask

  // Drive at posedge+1: valid_s rises 2 edges later, wren 3, ack 4; ack falls 3 edges after release
  task automatic handshake(input int g, input logic [7:0] b, input int hold);
    int w0, t_wr, t_ack, t_rel;
    w0 = wr_seen[g];
    push(g, b);
    hd[g] = b;
    hv[g] = 1'b1;
    t_wr = -1;
    t_ack = -1;
    for (int i = 1; i <= 30 && t_ack < 0; i++) begin
      tick();
      if (wren[g] && t_wr < 0) t_wr = i;
      if (ack[g]) t_ack = i;
    end
    check("latency_wren", 32'(t_wr), 32'd3);
    check("latency_ack", 32'(t_ack), 32'd4);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("ack_held", 32'(ack[g]), 32'd1);
    end
    hv[g] = 1'b0;
    t_rel = -1;
    for (int i = 1; i <= 30 && t_rel < 0; i++) begin
      tick();
      if (!ack[g]) t_rel = i;
    end
    check("latency_release", 32'(t_rel), 32'd3);
    check("writes_per_handshake", 32'(wr_seen[g] - w0), 32'd1);
    check("done_after_release", 32'(done[g]), 32'(mcnt[g] == img_of(g)));
    check("busy_after_release", 32'(busy[g]), 32'(mcnt[g] != img_of(g)));
`ifdef LOADER_CHECKSUM_EN
    check("checksum_running", 32'(csum[g]), 32'(msum[g]));
`endif
  endtask

  // enable dropped during the WRITE cycle: that write lands, then the loader idles
  task automatic write_abort(input int g, input logic [7:0] b);
    int w0, t_wr;
    w0 = wr_seen[g];
    push(g, b);
    hd[g] = b;
    hv[g] = 1'b1;
    t_wr = -1;
    for (int i = 1; i <= 30 && t_wr < 0; i++) begin
      tick();
      if (wren[g]) t_wr = i;
    end
    check("abort_latency_wren", 32'(t_wr), 32'd3);
    en[g] = 1'b0;
    tick();
    check("abort_busy", 32'(busy[g]), 32'd0);
    check("abort_wren", 32'(wren[g]), 32'd0);
    hv[g] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_ack", 32'(ack[g]), 32'd0);
      tick();
    end
    check("abort_one_write", 32'(wr_seen[g] - w0), 32'd1);
    mcnt[g] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, t_ack;
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      en[g] = 1'b0;
      hv[g] = 1'b0;
      hd[g] = 8'h00;
      mcnt[g] = 0;
      wr_seen[g] = 0;
`ifdef LOADER_CHECKSUM_EN
      msum[g] = 8'h00;
`endif
    end
    repeat (3) tick();
    for (int g = 0; g < N; g++) begin
      check("reset_ack", 32'(ack[g]), 32'd0);
      check("reset_wren", 32'(wren[g]), 32'd0);
      check("reset_busy", 32'(busy[g]), 32'd0);
      check("reset_done", 32'(done[g]), 32'd0);
      check("reset_addr", 32'(addr[g]), 32'(base_of(g)));
      check("reset_data", 32'(md[g]), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      check("reset_checksum", 32'(csum[g]), 32'd0);
`endif
    end
    check("reset_addr_literal", 32'(addr[1]), 32'h3FFFE);
    rst = 1'b0;
    tick();

    // Four-byte image at 0x00100
    start(0);
    handshake(0, 8'h11, 0);
    handshake(0, 8'h22, 0);
    handshake(0, 8'h33, 0);
    handshake(0, 8'h44, 0);
    check("load_done_literal", 32'(done[0]), 32'd1);
    check("last_addr_literal", 32'(addr[0]), 32'h00103);
    check("last_data_literal", 32'(md[0]), 32'h44);

    // DONE ignores the host
    hd[0] = 8'h99;
    hv[0] = 1'b1;
    repeat (8) tick();
    check("done_ignores_host_ack", 32'(ack[0]), 32'd0);
    hv[0] = 1'b0;
    repeat (4) tick();
    check("done_holds", 32'(done[0]), 32'd1);
    stop(0);

    // Long strobe, then abort after two bytes, then full reload from BASE_ADDR
    start(0);
    handshake(0, 8'h5A, 20);
    handshake(0, 8'h5B, 0);
    stop(0);
    start(0);
    handshake(0, 8'hA0, 0);
    handshake(0, 8'hA1, 0);
    handshake(0, 8'hA2, 0);
    handshake(0, 8'hA3, 0);
    check("reload_done_literal", 32'(done[0]), 32'd1);
    stop(0);

    // enable falls in the WRITE cycle
    start(0);
    write_abort(0, 8'hC3);
    check("abort_addr_literal", 32'(addr[0]), 32'h00100);

    // Address wrap past 2^18
    start(1);
    handshake(1, 8'hA1, 0);
    handshake(1, 8'hA2, 0);
    handshake(1, 8'hA3, 0);
    check("wrap_addr_literal", 32'(addr[1]), 32'h00000);
    check("wrap_done_literal", 32'(done[1]), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_literal_e6", 32'(csum[1]), 32'hE6);
`endif
    stop(1);
    start(1);
    handshake(1, 8'hFF, 0);
    handshake(1, 8'h02, 0);
    handshake(1, 8'h10, 0);
    check("second_load_done", 32'(done[1]), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_literal_11", 32'(csum[1]), 32'h11);
`endif
    stop(1);

    // Single-byte image
    start(2);
    handshake(2, 8'h5C, 0);
    check("single_byte_done", 32'(done[2]), 32'd1);
    check("single_byte_addr", 32'(addr[2]), 32'h00055);
    stop(2);

    // Reset while waiting for release
    start(0);
    w0 = wr_seen[0];
    push(0, 8'h77);
    hd[0] = 8'h77;
    hv[0] = 1'b1;
    t_ack = -1;
    for (int i = 1; i <= 30 && t_ack < 0; i++) begin
      tick();
      if (ack[0]) t_ack = i;
    end
    check("rst_test_ack_seen", 32'(t_ack), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ack", 32'(ack[0]), 32'd0);
    check("rst_async_busy", 32'(busy[0]), 32'd0);
    check("rst_async_addr", 32'(addr[0]), 32'h00100);
    repeat (3) tick();
    hv[0] = 1'b0;
    en[0] = 1'b0;
    check("rst_no_extra_write", 32'(wr_seen[0] - w0), 32'd1);
    rst = 1'b0;
    repeat (3) tick();
    check("rst_idle_busy", 32'(busy[0]), 32'd0);
    check("rst_idle_wren", 32'(wren[0]), 32'd0);

    check("expected_writes_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
